// File: rtl/l1_load_requester.sv
// L1-side LOAD_REQ initiator: one outstanding miss, sends LOAD_REQ on msg1, waits for the grant on msg2.
// Optional retry/timeout logic is enabled by defining L1_LOAD_REQUESTER_TIMEOUT_EN.
module l1_load_requester #(
  parameter logic [5:0] SRC_ID      = 6'd0,
  parameter logic [7:0] TIMEOUT_CYC = 8'd200,
  parameter logic [1:0] MAX_RETRY   = 2'd3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req_valid,
  output logic        core_req_ready,
  input  logic [25:0] core_req_tag,
  output logic        core_resp_valid,
  input  logic        core_resp_ready,
  output logic [63:0] core_resp_data,
  output logic        core_resp_err,
  output logic        msg1_valid,
  input  logic        msg1_ready,
  output logic [7:0]  msg1_type,
  output logic [5:0]  msg1_source,
  output logic [25:0] msg1_tag,
  output logic [63:0] msg1_data,
  input  logic        msg2_valid,
  output logic        msg2_ready,
  input  logic [7:0]  msg2_type,
  input  logic [25:0] msg2_tag,
  input  logic [63:0] msg2_data,
  output logic [3:0]  progress_cnt,
  output logic        unexp_seen
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam logic [7:0] LOAD_REQ   = 8'h1f;
  localparam logic [7:0] DATA_GRANT = 8'h1d;
  localparam logic [7:0] PROG_LO    = 8'h10;
  localparam logic [7:0] PROG_HI    = 8'h14;

  state_t      state_reg;
  logic [25:0] req_tag_reg;

  logic tag_match;
  logic is_grant;
  logic is_progress;

  assign tag_match   = (msg2_tag == req_tag_reg);
  assign is_grant    = (msg2_type == DATA_GRANT) && tag_match;
  assign is_progress = (msg2_type >= PROG_LO) && (msg2_type <= PROG_HI) && tag_match;

`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;
  logic [1:0] retry_reg;
  logic       resp_err_reg;
  logic       timeout_hit;

  assign timeout_hit   = (wait_cnt_reg + 8'd1 >= TIMEOUT_CYC);
  assign core_resp_err = resp_err_reg;
`else
  logic unused_cfg;

  assign unused_cfg    = ^{TIMEOUT_CYC, MAX_RETRY};
  assign core_resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      req_tag_reg     <= '0;
      core_req_ready  <= 1'b1;
      core_resp_valid <= 1'b0;
      core_resp_data  <= '0;
      msg1_valid      <= 1'b0;
      msg1_type       <= '0;
      msg1_source     <= '0;
      msg1_tag        <= '0;
      msg1_data       <= '0;
      msg2_ready      <= 1'b0;
      progress_cnt    <= '0;
      unexp_seen      <= 1'b0;
`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
      wait_cnt_reg    <= '0;
      retry_reg       <= '0;
      resp_err_reg    <= 1'b0;
`endif
    end else begin
      // Traffic from the L2 outside WAIT cannot belong to a live request (e.g. a grant after an abort).
      if (state_reg != WAIT && msg2_valid) begin
        unexp_seen <= 1'b1;
      end

      case (state_reg)
        IDLE: begin
          if (core_req_valid) begin
            state_reg      <= SEND;
            req_tag_reg    <= core_req_tag;
            progress_cnt   <= '0;
            core_req_ready <= 1'b0;
            msg1_valid     <= 1'b1;
            msg1_type      <= LOAD_REQ;
            msg1_source    <= SRC_ID;
            msg1_tag       <= core_req_tag;
            msg1_data      <= '0;
`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
            retry_reg      <= '0;
`endif
          end
        end

        SEND: begin
          if (msg1_valid && msg1_ready) begin
            state_reg  <= WAIT;
            msg1_valid <= 1'b0;
            msg2_ready <= 1'b1;
`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end
        end

        WAIT: begin
          if (msg2_valid && is_grant) begin
            state_reg       <= RESP;
            msg2_ready      <= 1'b0;
            core_resp_valid <= 1'b1;
            core_resp_data  <= msg2_data;
`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
            resp_err_reg    <= 1'b0;
`endif
          end else if (msg2_valid && is_progress) begin
            if (progress_cnt != 4'hf) begin
              progress_cnt <= progress_cnt + 4'd1;
            end
`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
          end else begin
            if (msg2_valid) begin
              unexp_seen <= 1'b1;
            end
`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
            // Dropped beats do not count as L2 liveness, so the counter keeps running.
            if (timeout_hit) begin
              msg2_ready   <= 1'b0;
              wait_cnt_reg <= '0;
              if (retry_reg == MAX_RETRY) begin
                state_reg       <= RESP;
                core_resp_valid <= 1'b1;
                core_resp_data  <= '0;
                resp_err_reg    <= 1'b1;
              end else begin
                state_reg  <= SEND;
                retry_reg  <= retry_reg + 2'd1;
                msg1_valid <= 1'b1;
              end
            end else begin
              wait_cnt_reg <= wait_cnt_reg + 8'd1;
            end
`endif
          end
        end

        RESP: begin
          if (core_resp_valid && core_resp_ready) begin
            state_reg       <= IDLE;
            core_resp_valid <= 1'b0;
            core_req_ready  <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_l1_load_requester.sv
// Scoreboard bench for l1_load_requester: expected msg1 sends and core completions are queued by the
// stimulus and popped by an independent monitor on the falling edge.
module tb_l1_load_requester;

  localparam logic [5:0] SRC = 6'h2a;

  logic        clk = 1'b0;
  logic        rst;
  logic        core_req_valid;
  logic        core_req_ready;
  logic [25:0] core_req_tag;
  logic        core_resp_valid;
  logic        core_resp_ready;
  logic [63:0] core_resp_data;
  logic        core_resp_err;
  logic        msg1_valid;
  logic        msg1_ready;
  logic [7:0]  msg1_type;
  logic [5:0]  msg1_source;
  logic [25:0] msg1_tag;
  logic [63:0] msg1_data;
  logic        msg2_valid;
  logic        msg2_ready;
  logic [7:0]  msg2_type;
  logic [25:0] msg2_tag;
  logic [63:0] msg2_data;
  logic [3:0]  progress_cnt;
  logic        unexp_seen;

  int total = 0;
  int bad   = 0;
  int exp_sends = 0;
  int got_sends = 0;

  logic [25:0] msg1_q[$];
  logic [64:0] resp_q[$];

  l1_load_requester #(
    .SRC_ID(SRC),
    .TIMEOUT_CYC(8'd10),
    .MAX_RETRY(2'd3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .core_req_valid(core_req_valid),
    .core_req_ready(core_req_ready),
    .core_req_tag(core_req_tag),
    .core_resp_valid(core_resp_valid),
    .core_resp_ready(core_resp_ready),
    .core_resp_data(core_resp_data),
    .core_resp_err(core_resp_err),
    .msg1_valid(msg1_valid),
    .msg1_ready(msg1_ready),
    .msg1_type(msg1_type),
    .msg1_source(msg1_source),
    .msg1_tag(msg1_tag),
    .msg1_data(msg1_data),
    .msg2_valid(msg2_valid),
    .msg2_ready(msg2_ready),
    .msg2_type(msg2_type),
    .msg2_tag(msg2_tag),
    .msg2_data(msg2_data),
    .progress_cnt(progress_cnt),
    .unexp_seen(unexp_seen)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [25:0] tag);
    core_req_valid = 1'b1;
    core_req_tag   = tag;
    msg1_q.push_back(tag);
    exp_sends++;
    cyc();
    core_req_valid = 1'b0;
  endtask

  task automatic beat(input logic [7:0] t, input logic [25:0] tag, input logic [63:0] d);
    msg2_valid = 1'b1;
    msg2_type  = t;
    msg2_tag   = tag;
    msg2_data  = d;
    cyc();
    msg2_valid = 1'b0;
  endtask

  task automatic wait_msg2_ready(input int limit);
    for (int i = 0; i < limit && !msg2_ready; i++) cyc();
    chk("wait_msg2_ready", 64'(msg2_ready), 64'd1);
  endtask

  task automatic wait_resp_valid(input int limit);
    for (int i = 0; i < limit && !core_resp_valid; i++) cyc();
    chk("wait_resp_valid", 64'(core_resp_valid), 64'd1);
  endtask

  task automatic complete();
    core_resp_ready = 1'b1;
    cyc();
    core_resp_ready = 1'b0;
    chk("ready_after_resp", 64'(core_req_ready), 64'd1);
  endtask

  // Monitor: compares every msg1 send and core completion against the queued expectations.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (msg1_valid && msg1_ready) begin
          got_sends++;
          if (msg1_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL msg1_extra actual_tag=%0h required=none", msg1_tag);
          end else begin
            logic [25:0] et;
            et = msg1_q.pop_front();
            chk("msg1_type", 64'(msg1_type), 64'h1f);
            chk("msg1_source", 64'(msg1_source), 64'(SRC));
            chk("msg1_tag", 64'(msg1_tag), 64'(et));
            chk("msg1_data", msg1_data, 64'd0);
          end
        end
        if (core_resp_valid && core_resp_ready) begin
          if (resp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL resp_extra actual_data=%0h required=none", core_resp_data);
          end else begin
            logic [64:0] er;
            er = resp_q.pop_front();
            chk("resp_data", core_resp_data, er[63:0]);
            chk("resp_err", 64'(core_resp_err), 64'(er[64]));
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    core_req_valid = 1'b0;
    core_req_tag = '0;
    core_resp_ready = 1'b0;
    msg1_ready = 1'b0;
    msg2_valid = 1'b0;
    msg2_type = '0;
    msg2_tag = '0;
    msg2_data = '0;
    cyc();
    cyc();
    rst = 1'b0;

    // Reset values
    chk("rst_req_ready", 64'(core_req_ready), 64'd1);
    chk("rst_resp_valid", 64'(core_resp_valid), 64'd0);
    chk("rst_msg1_valid", 64'(msg1_valid), 64'd0);
    chk("rst_msg2_ready", 64'(msg2_ready), 64'd0);
    chk("rst_resp_data", core_resp_data, 64'd0);
    chk("rst_resp_err", 64'(core_resp_err), 64'd0);
    chk("rst_msg1_fields", 64'({msg1_type, msg1_source, msg1_tag}), 64'd0);
    chk("rst_progress", 64'(progress_cnt), 64'd0);
    chk("rst_unexp", 64'(unexp_seen), 64'd0);

    // Basic hit: completion 3 cycles after the request
    msg1_ready = 1'b1;
    resp_q.push_back({1'b0, 64'hdead_beef});
    issue(26'h0abc);
    chk("basic_msg1_valid", 64'(msg1_valid), 64'd1);
    cyc();
    chk("basic_msg2_ready", 64'(msg2_ready), 64'd1);
    beat(8'h1d, 26'h0abc, 64'hdead_beef);
    chk("basic_latency3", 64'(core_resp_valid), 64'd1);
    complete();
    $display("txn basic tag=0abc done");

    // msg1 back-pressure for 5 cycles, then core_resp back-pressure for 4
    msg1_ready = 1'b0;
    resp_q.push_back({1'b0, 64'h0123_4567_89ab_cdef});
    issue(26'h1234567);
    for (int i = 0; i < 5; i++) begin
      chk("bp_msg1_valid", 64'(msg1_valid), 64'd1);
      chk("bp_msg1_fields", 64'({msg1_type, msg1_source, msg1_tag}), 64'({8'h1f, SRC, 26'h1234567}));
      cyc();
    end
    msg1_ready = 1'b1;
    cyc();
    chk("bp_msg1_dropped", 64'(msg1_valid), 64'd0);
    wait_msg2_ready(10);
    beat(8'h1d, 26'h1234567, 64'h0123_4567_89ab_cdef);
    wait_resp_valid(10);
    core_req_valid = 1'b1;
    core_req_tag = 26'h3333333;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("hold_resp_valid", 64'(core_resp_valid), 64'd1);
      chk("hold_req_ready", 64'(core_req_ready), 64'd0);
      chk("hold_no_msg1", 64'(msg1_valid), 64'd0);
    end
    core_req_valid = 1'b0;
    complete();
    $display("txn backpressure tag=1234567 done");

    // Intermediate progress beats, then saturation
    resp_q.push_back({1'b0, 64'h5555_aaaa_0000_ffff});
    issue(26'h2a55a5);
    wait_msg2_ready(10);
    beat(8'h10, 26'h2a55a5, 64'd0);
    beat(8'h14, 26'h2a55a5, 64'd0);
    chk("prog_cnt2", 64'(progress_cnt), 64'd2);
    chk("prog_still_wait", 64'(msg2_ready), 64'd1);
    for (int i = 0; i < 15; i++) beat(8'h11, 26'h2a55a5, 64'd0);
    chk("prog_sat15", 64'(progress_cnt), 64'd15);
    chk("prog_no_unexp", 64'(unexp_seen), 64'd0);
    beat(8'h1d, 26'h2a55a5, 64'h5555_aaaa_0000_ffff);
    chk("prog_resp_valid", 64'(core_resp_valid), 64'd1);
    complete();
    $display("txn progress tag=2a55a5 done");

    // Unexpected traffic is dropped
    resp_q.push_back({1'b0, 64'hfeed_f00d_cafe_0001});
    issue(26'h0777);
    wait_msg2_ready(10);
    beat(8'h1d, 26'h0778, 64'h1111);
    beat(8'h05, 26'h0777, 64'h2222);
    chk("unexp_flag", 64'(unexp_seen), 64'd1);
    chk("unexp_still_wait", 64'(msg2_ready), 64'd1);
    chk("unexp_no_resp", 64'(core_resp_valid), 64'd0);
    chk("unexp_progress0", 64'(progress_cnt), 64'd0);
    beat(8'h1d, 26'h0777, 64'hfeed_f00d_cafe_0001);
    chk("unexp_resp_valid", 64'(core_resp_valid), 64'd1);
    complete();
    $display("txn unexpected tag=0777 done");

    // No msg2 traffic: retries then error, or indefinite wait without the timeout option
`ifdef L1_LOAD_REQUESTER_TIMEOUT_EN
    for (int i = 0; i < 3; i++) begin
      msg1_q.push_back(26'h0bad);
      exp_sends++;
    end
    resp_q.push_back({1'b1, 64'd0});
    issue(26'h0bad);
    wait_resp_valid(300);
    complete();
    $display("txn timeout tag=0bad done");
`else
    resp_q.push_back({1'b0, 64'h0bad_0bad});
    issue(26'h0bad);
    for (int i = 0; i < 300; i++) cyc();
    chk("nto_still_wait", 64'(msg2_ready), 64'd1);
    chk("nto_no_resp", 64'(core_resp_valid), 64'd0);
    beat(8'h1d, 26'h0bad, 64'h0bad_0bad);
    wait_resp_valid(5);
    complete();
    $display("txn no_timeout tag=0bad done");
`endif

    // Reset while in WAIT, then a late grant
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("rst_unexp_clear", 64'(unexp_seen), 64'd0);
    issue(26'h1234);
    wait_msg2_ready(10);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("abort_req_ready", 64'(core_req_ready), 64'd1);
    chk("abort_msg2_ready", 64'(msg2_ready), 64'd0);
    chk("abort_msg1_valid", 64'(msg1_valid), 64'd0);
    beat(8'h1d, 26'h1234, 64'h9999);
    chk("late_grant_unexp", 64'(unexp_seen), 64'd1);
    chk("late_grant_no_resp", 64'(core_resp_valid), 64'd0);
    $display("txn reset_abort tag=1234 done");

    cyc();
    chk("msg1_q_empty", 64'(msg1_q.size()), 64'd0);
    chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
    chk("send_count", 64'(got_sends), 64'(exp_sends));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

endmodule
